// File: rtl/dfp_round_pipe_pkg.sv
// Shared types for the decimal-FP rounding pipeline: rounding-mode enum
// and the per-mode increment decision used by stage 1.
package dfp_round_pipe_pkg;

   localparam int DFP_RM_W = 3;

   typedef enum logic [DFP_RM_W-1:0] {
      RM_CEIL      = 3'd0,
      RM_FLOOR     = 3'd1,
      RM_HALF_UP   = 3'd2,
      RM_HALF_EVEN = 3'd3,
      RM_DOWN      = 3'd4,
      RM_HALF_DOWN = 3'd5,
      RM_AWAY      = 3'd6,
      RM_RSVD      = 3'd7
   } dfp_rm_t;

   function automatic logic round_inc(
      input dfp_rm_t rm,
      input logic    sign,
      input logic    l,
      input logic    tail,
      input logic    above,
      input logic    half
   );
      logic inc;
      inc = 1'b0;
      unique case (rm)
         RM_CEIL:      inc = tail & ~sign;
         RM_FLOOR:     inc = tail & sign;
         RM_HALF_UP:   inc = above | half;
         RM_HALF_EVEN: inc = above | (half & l);
         RM_DOWN:      inc = 1'b0;
         RM_HALF_DOWN: inc = above;
         RM_AWAY:      inc = tail;
         default:      inc = 1'b0;
      endcase
      return inc;
   endfunction

endpackage

// File: rtl/dfp_round_pipe_bcd_inc.sv
// N-digit BCD increment by 0/1 with carry-out.
// Ports: a_i digits, inc_i addend bit, sum_o digits, cy_o carry out.
module dfp_bcd_inc #(
   parameter int N = 25
) (
   input  logic [4*N-1:0] a_i,
   input  logic           inc_i,
   output logic [4*N-1:0] sum_o,
   output logic           cy_o
);

   logic       c;
   logic [3:0] d;

   always_comb begin
      c     = inc_i;
      d     = 4'd0;
      sum_o = '0;
      for (int i = 0; i < N; i++) begin
         d = a_i[4*i +: 4];
         if (c && d == 4'd9) begin
            sum_o[4*i +: 4] = 4'd0;
         end else begin
            sum_o[4*i +: 4] = d + {3'b000, c};
            c = 1'b0;
         end
      end
      cy_o = c;
   end

endmodule

// File: rtl/dfp_round_pipe.sv
// 3-stage handshaked decimal-FP rounding pipe: S1 decide, S2 BCD increment,
// S3 select/overflow. Ports: in_* beat (valid/ready), out_* result (valid/ready).
module dfp_round_pipe
   import dfp_round_pipe_pkg::*;
#(
   parameter int              N       = 25,
   parameter int              EXPW    = 12,
   parameter logic [EXPW-1:0] EXP_INF = 'hBFF,
   parameter int              TAGW    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DFP_RM_W-1:0] in_rm,
   input  logic                in_sign,
   input  logic [EXPW-1:0]     in_exp,
   input  logic [4*(N+1)-1:0]  in_sig,
   input  logic                in_sticky,
   input  logic                in_nan,
   input  logic                in_qnan,
   input  logic                in_snan,
   input  logic                in_inf,
   input  logic [TAGW-1:0]     in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_sign,
   output logic [EXPW-1:0]     out_exp,
   output logic [4*N-1:0]      out_sig,
   output logic                out_nan,
   output logic                out_qnan,
   output logic                out_snan,
   output logic                out_inf,
   output logic                out_inexact,
   output logic                out_ovf,
   output logic [TAGW-1:0]     out_tag
);

   typedef struct packed {
      logic            inc;
      logic            inx;
      logic            sign;
      logic [EXPW-1:0] exp;
      logic [4*N-1:0]  sig;
      logic            nan;
      logic            qnan;
      logic            snan;
      logic            inf;
      logic [TAGW-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic            inx;
      logic            sign;
      logic [EXPW:0]   exp2;
      logic [4*N-1:0]  sum;
      logic            cy;
      logic            nan;
      logic            qnan;
      logic            snan;
      logic            inf;
      logic [TAGW-1:0] tag;
   } s2_t;

   typedef struct packed {
      logic            sign;
      logic [EXPW-1:0] exp;
      logic [4*N-1:0]  sig;
      logic            nan;
      logic            qnan;
      logic            snan;
      logic            inf;
      logic            inx;
      logic            ovf;
      logic [TAGW-1:0] tag;
   } s3_t;

   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;
   s3_t  s3_d, s3_q;
   logic v1_q, v2_q, v3_q;
   logic en1, en2, en3;

   // One enable rule: a stage may load when empty or when its successor moves.
   assign en3      = ~v3_q | out_ready;
   assign en2      = ~v2_q | en3;
   assign en1      = ~v1_q | en2;
   assign in_ready = en1;

   logic [3:0] g;
   logic       tail, above, half, spec;

   assign g     = in_sig[3:0];
   assign tail  = (g != 4'd0) | in_sticky;
   assign above = (g > 4'd5) | ((g == 4'd5) & in_sticky);
   assign half  = (g == 4'd5) & ~in_sticky;
   assign spec  = in_nan | in_qnan | in_snan | in_inf;

   always_comb begin
      s1_d      = '0;
      s1_d.sign = in_sign;
      s1_d.exp  = in_exp;
      s1_d.sig  = in_sig[4*(N+1)-1:4];
      s1_d.nan  = in_nan;
      s1_d.qnan = in_qnan;
      s1_d.snan = in_snan;
      s1_d.inf  = in_inf;
      s1_d.tag  = in_tag;
      s1_d.inc  = ~spec & round_inc(dfp_rm_t'(in_rm), in_sign,
                                    in_sig[4], tail, above, half);
      s1_d.inx  = ~spec & tail;
   end

   logic [4*N-1:0] sum;
   logic           cy;

   dfp_bcd_inc #(.N(N)) u_inc (
      .a_i   (s1_q.sig),
      .inc_i (s1_q.inc),
      .sum_o (sum),
      .cy_o  (cy)
   );

   // With inc=0 the sum equals the kept digits and exp2 equals exp,
   // so S3 needs only sum/cy/exp2.
   always_comb begin
      s2_d      = '0;
      s2_d.inx  = s1_q.inx;
      s2_d.sign = s1_q.sign;
      s2_d.exp2 = {1'b0, s1_q.exp} + {{EXPW{1'b0}}, cy};
      s2_d.sum  = sum;
      s2_d.cy   = cy;
      s2_d.nan  = s1_q.nan;
      s2_d.qnan = s1_q.qnan;
      s2_d.snan = s1_q.snan;
      s2_d.inf  = s1_q.inf;
      s2_d.tag  = s1_q.tag;
   end

   always_comb begin
      s3_d      = '0;
      s3_d.sign = s2_q.sign;
      s3_d.exp  = s2_q.exp2[EXPW-1:0];
      s3_d.sig  = s2_q.sum;
      s3_d.nan  = s2_q.nan;
      s3_d.qnan = s2_q.qnan;
      s3_d.snan = s2_q.snan;
      s3_d.inf  = s2_q.inf;
      s3_d.inx  = s2_q.inx;
      s3_d.tag  = s2_q.tag;
      if (s2_q.cy) begin
         if (s2_q.exp2 == {1'b0, EXP_INF}) begin
            s3_d.inf = 1'b1;
            s3_d.ovf = 1'b1;
            s3_d.sig = '0;
            s3_d.exp = EXP_INF;
         end else begin
            s3_d.sig = {4'h1, {(4*(N-1)){1'b0}}};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         if (en1) begin
            v1_q <= in_valid;
            if (in_valid) s1_q <= s1_d;
         end
         if (en2) begin
            v2_q <= v1_q;
            if (v1_q) s2_q <= s2_d;
         end
         if (en3) begin
            v3_q <= v2_q;
            if (v2_q) s3_q <= s3_d;
         end
      end
   end

   assign out_valid   = v3_q;
   assign out_sign    = s3_q.sign;
   assign out_exp     = s3_q.exp;
   assign out_sig     = s3_q.sig;
   assign out_nan     = s3_q.nan;
   assign out_qnan    = s3_q.qnan;
   assign out_snan    = s3_q.snan;
   assign out_inf     = s3_q.inf;
   assign out_inexact = s3_q.inx;
   assign out_ovf     = s3_q.ovf;
   assign out_tag     = s3_q.tag;

endmodule
